fp_fma_round_pipe: RTL and testbench
====================================

// Module: fp_fma_round_pipe
// PURPOSE
//  Downstream stage of the fused multiply-add. Consumes fp_fma's unrounded Structs::uround_res_t.
//  Applies IEEE-754 rounding under rnd_i, resolves overflow/underflow and packs the final result.
//  Raises RISC-V fflags. 2-stage valid/ready pipeline between the FMA datapath and writeback.
// PARAMETERS
//  FP_FORMAT  FP32  fp_format_e; sets FP_WIDTH/EXP_WIDTH/MANT_WIDTH via fp_width/exp_bits/man_bits
// PORTS
//  clk_i         in   1         clock
//  rst_ni        in   1         async active-low reset
//  flush_i       in   1         sync kill of both stages
//  valid_i       in   1         upstream result valid
//  ready_o       out  1         stage 1 can accept
//  urnd_i        in   uround_res_t  u_result{sign,exp,mant}, rs[1:0], round_en, invalid, exp_cout[1:0]
//  rnd_i         in   roundmode_e   rounding mode, sampled with urnd_i
//  mul_ovf_i     in   1         product overflowed, result must saturate
//  valid_o       out  1         result valid
//  ready_i       in   1         downstream accepts
//  result_o      out  FP_WIDTH  packed rounded result
//  fflags_o      out  5         {NV,DZ,OF,UF,NX}
// BEHAVIOUR
//  Reset: s1_valid=s2_valid=0, valid_o=0, ready_o=1, result_o=0, fflags_o=0.
//  Handshake: transfer when valid&ready.
//   - s2 advances when !s2_valid | ready_i.
//   - s1 advances when !s1_valid | s2 advances.
//   - ready_o = that s1-advance term (combinational).
//  Latency: 2 cycles input->valid_o. Throughput 1/cycle. Outputs hold stable while valid_o & !ready_i.
//  flush_i: clears both valids next edge; any input offered that cycle is dropped.
//  Async reset mid-transaction: same as flush, in-flight data lost.
//  S1, registered:
//   - lsb = mant[0], r = rs[1], s = rs[0], inexact = round_en & (r|s).
//   - inc, only when round_en:
//     RNE  r&(s|lsb)
//     RTZ  0
//     RDN  (r|s)&sign
//     RUP  (r|s)&~sign
//     RMM  r
//   - ovf_pre = mul_ovf_i | exp_cout==2'b01 | (exp==all-ones & round_en).
//  S2, registered into outputs:
//   - {c,m} = mant+inc. c=1 -> mant=0, exp=exp+1; exp 0->1 (subnormal->normal) uses the same rule.
//   - ovf = ovf_pre | (c & exp+1==all-ones).
//   - On ovf, RNE/RMM give +-INF. RTZ gives max finite. RDN gives -INF if sign else +max. RUP gives +INF if !sign else -max.
//  Pass-through: round_en=0 -> result = u_result unchanged (NaN/INF/exact zero/R_IND), no NX/OF/UF.
//  Flags:
//   - NV = invalid.
//   - DZ = 0.
//   - OF = ovf & round_en.
//   - NX = inexact | OF.
//   - UF = NX & exp_pre==0 (tininess before rounding, fixed decision).
//   - UF also set when inexact & c carried subnormal to exp=1.
//  Width rule: mant/exp adders are MANT_WIDTH+1 / EXP_WIDTH+1 bits; carry must never wrap silently.
// STRUCTURE
//  fp_pkg additions:
//   - fflags_t packed struct {nv,dz,of,uf,nx}.
//   - function rnd_increment(roundmode_e, sign, lsb, r, s).
//   - function ovf_result(sign, roundmode_e) returning packed INF/max-finite.
//  One combinational sub-module, fp_rnd_core: S2 math (mant add, exp carry, ovf select, flag build).
//  Reusable by fp_add/fp_mul writeback later.
//  Top level holds only the two pipeline registers and the handshake.
// TESTING
//  1. RNE tie-to-even: FP32 sign=0 exp=0x7F mant=0x000001, rs=2'b10, round_en=1
//     -> 0x3F800002, NX=1, latency exactly 2.
//  2. Mantissa carry: exp=0x7F mant=0x7FFFFF, rs=2'b11, RNE -> 0x40000000, NX=1.
//     Same input with RTZ -> 0x3FFFFFFF.
//  3. Overflow: exp=0xFE mant=0x7FFFFF rs=2'b10.
//     RNE -> 0x7F800000, OF=1, NX=1. RTZ -> 0x7F7FFFFF. RDN sign=1 -> 0xFF800000.
//  4. Subnormal/UF: exp=0 mant=0x000010 rs=2'b01, RNE -> 0x00000010, UF=1, NX=1.
//     exp=0 mant=0x7FFFFF rs=2'b11 -> 0x00800000, UF=1.
//  5. Pass-through: R_IND with invalid=1, round_en=0 -> 0xFFC00000, fflags=5'b10000.
//  6. Backpressure: 4 back-to-back inputs, ready_i low cycles 2-4.
//     -> ready_o drops once both stages full, no loss/duplication, order kept.
//     flush_i mid-burst -> valid_o=0 next cycle; rst_ni pulse mid-burst -> all outputs to reset values.

Source files
------------

// File: rtl/fp_fma_round_pipe_pkg.sv
// Shared types and helpers for the FMA rounding/writeback stage.
// The struct widths follow the FP32 default format.
package fp_fma_round_pipe_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP64 = 2'd1,
        FP16 = 2'd2
    } fp_format_e;

    function automatic int fp_width(fp_format_e fmt);
        case (fmt)
            FP64:    return 64;
            FP16:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            default: return 23;
        endcase
    endfunction

    localparam fp_format_e FP_FORMAT_DEF = FP32;
    localparam int FP_WIDTH   = fp_width(FP_FORMAT_DEF);
    localparam int EXP_WIDTH  = exp_bits(FP_FORMAT_DEF);
    localparam int MANT_WIDTH = man_bits(FP_FORMAT_DEF);

    // RISC-V frm encoding
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } roundmode_e;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH-1:0] mant;
    } fp_t;

    typedef struct packed {
        fp_t        u_result;
        logic [1:0] rs;
        logic       round_en;
        logic       invalid;
        logic [1:0] exp_cout;
    } uround_res_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Round-up decision; reserved mode encodings fall back to round-to-nearest-even.
    function automatic logic rnd_increment(roundmode_e rm, logic sign, logic lsb, logic r, logic s);
        case (rm)
            RNE:     return r & (s | lsb);
            RTZ:     return 1'b0;
            RDN:     return (r | s) & sign;
            RUP:     return (r | s) & ~sign;
            RMM:     return r;
            default: return r & (s | lsb);
        endcase
    endfunction

    // Saturated result on overflow: infinity when the mode rounds away from zero, else max finite.
    function automatic fp_t ovf_result(logic sign, roundmode_e rm);
        fp_t inf_v;
        fp_t max_v;
        inf_v = '{sign: sign, exp: '1, mant: '0};
        max_v = '{sign: sign, exp: {{(EXP_WIDTH-1){1'b1}}, 1'b0}, mant: '1};
        case (rm)
            RTZ:     return max_v;
            RDN:     return sign ? inf_v : max_v;
            RUP:     return sign ? max_v : inf_v;
            default: return inf_v;
        endcase
    endfunction

endpackage

// File: rtl/fp_fma_round_pipe_rnd_core.sv
// Combinational rounding core: mantissa increment, exponent carry,
// overflow saturation and fflags. Shared with other FP writeback stages.
module fp_rnd_core
    import fp_fma_round_pipe_pkg::*;
#(
    parameter int EXP_W = EXP_WIDTH,
    parameter int MAN_W = MANT_WIDTH
) (
    input  logic               sign,
    input  logic [EXP_W-1:0]   exp_pre,
    input  logic [MAN_W-1:0]   mant_pre,
    input  logic               inc,
    input  logic               inexact,
    input  logic               ovf_pre,
    input  logic               round_en,
    input  logic               invalid,
    input  roundmode_e         rnd,
    input  logic [EXP_W+MAN_W:0] pass,
    output logic [EXP_W+MAN_W:0] result,
    output fflags_t            fflags
);

    logic [MAN_W:0] mant_sum;
    logic           carry;
    logic [EXP_W:0] exp_sum;
    logic [MAN_W-1:0] mant_out;
    logic           ovf;
    logic           of_flag;
    logic           nx_flag;
    logic           tiny_pre;

    // Rounding arithmetic with one guard bit per adder so a carry is always visible.
    always_comb begin
        mant_sum = {1'b0, mant_pre} + {{MAN_W{1'b0}}, inc};
        carry    = mant_sum[MAN_W];
        exp_sum  = {1'b0, exp_pre} + {{EXP_W{1'b0}}, carry};
        mant_out = carry ? '0 : mant_sum[MAN_W-1:0];
        ovf      = ovf_pre | (carry & (exp_sum[EXP_W] | (&exp_sum[EXP_W-1:0])));
        of_flag  = ovf & round_en;
        nx_flag  = inexact | of_flag;
        tiny_pre = (exp_pre == '0);

        if (!round_en) begin
            result = pass;
        end else if (ovf) begin
            result = ovf_result(sign, rnd);
        end else begin
            result = {sign, exp_sum[EXP_W-1:0], mant_out};
        end

        // Tininess is judged before rounding, so a subnormal that rounds up to
        // the smallest normal still reports underflow when inexact.
        fflags.nv = invalid;
        fflags.dz = 1'b0;
        fflags.of = of_flag;
        fflags.nx = nx_flag;
        fflags.uf = (nx_flag & tiny_pre) | (inexact & carry & tiny_pre);
    end

endmodule

// File: rtl/fp_fma_round_pipe.sv
// Two-stage valid/ready rounding pipeline between the FMA datapath and writeback.
// Stage 1 registers the rounding decision, stage 2 registers the packed result.
module fp_fma_round_pipe
    import fp_fma_round_pipe_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  uround_res_t                      urnd_i,
    input  roundmode_e                       rnd_i,
    input  logic                             mul_ovf_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [fp_width(FP_FORMAT)-1:0]   result_o,
    output logic [4:0]                       fflags_o
);

    localparam int EXP_W = exp_bits(FP_FORMAT);
    localparam int MAN_W = man_bits(FP_FORMAT);

    typedef struct packed {
        logic       inc;
        logic       inexact;
        logic       ovf_pre;
        logic       round_en;
        logic       invalid;
        roundmode_e rnd;
        fp_t        u;
    } s1_t;

    s1_t     s1_d;
    s1_t     s1_q;
    logic    s1_valid;
    logic    s2_valid;
    logic    s1_adv;
    logic    s2_adv;
    logic [EXP_W+MAN_W:0] core_result;
    fflags_t core_flags;

    assign s2_adv  = !s2_valid || ready_i;
    assign s1_adv  = !s1_valid || s2_adv;
    assign ready_o = s1_adv;
    assign valid_o = s2_valid;

    // Stage 1 decision: round increment, inexact and early overflow.
    always_comb begin
        s1_d          = '0;
        s1_d.u        = urnd_i.u_result;
        s1_d.rnd      = rnd_i;
        s1_d.round_en = urnd_i.round_en;
        s1_d.invalid  = urnd_i.invalid;
        s1_d.inexact  = urnd_i.round_en & (urnd_i.rs[1] | urnd_i.rs[0]);
        s1_d.inc      = urnd_i.round_en &
                        rnd_increment(rnd_i, urnd_i.u_result.sign, urnd_i.u_result.mant[0],
                                      urnd_i.rs[1], urnd_i.rs[0]);
        s1_d.ovf_pre  = mul_ovf_i | (urnd_i.exp_cout == 2'b01) |
                        ((&urnd_i.u_result.exp) & urnd_i.round_en);
    end

    // Stage 1 register; payload only loads on an accepted input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_q <= s1_d;
            end
        end
    end

    fp_rnd_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_rnd_core (
        .sign     (s1_q.u.sign),
        .exp_pre  (s1_q.u.exp),
        .mant_pre (s1_q.u.mant),
        .inc      (s1_q.inc),
        .inexact  (s1_q.inexact),
        .ovf_pre  (s1_q.ovf_pre),
        .round_en (s1_q.round_en),
        .invalid  (s1_q.invalid),
        .rnd      (s1_q.rnd),
        .pass     (s1_q.u),
        .result   (core_result),
        .fflags   (core_flags)
    );

    // Stage 2 register drives the outputs; they hold while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            result_o <= '0;
            fflags_o <= '0;
        end else if (flush_i) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_o <= core_result;
                fflags_o <= core_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_fma_round_pipe.sv
// Self-checking bench for fp_fma_round_pipe: directed literal cases,
// backpressure/flush/reset scenarios and randomized traffic against a value-level model.
module tb_fp_fma_round_pipe;
    import fp_fma_round_pipe_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    uround_res_t urnd_i;
    roundmode_e  rnd_i;
    logic        mul_ovf_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    bit saw_stall = 0;
    logic [36:0] q[$];

    fp_fma_round_pipe #(.FP_FORMAT(FP32)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .urnd_i    (urnd_i),
        .rnd_i     (rnd_i),
        .mul_ovf_i (mul_ovf_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .fflags_o  (fflags_o)
    );

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value-level reference: rounding is an integer increment of the {exp,mant} magnitude,
    // which lets the carry ripple into the exponent naturally.
    function automatic logic [36:0] model(input logic [31:0] u, input logic [1:0] rs, input logic re,
                                          input logic inv, input logic [1:0] ec, input logic [2:0] rm,
                                          input logic mo);
        logic sign, r, s, ovf, to_inf, nx;
        int unsigned inc;
        longint unsigned mag;
        logic [31:0] res;
        sign = u[31];
        r = rs[1];
        s = rs[0];
        if (!re) return {u, inv, 4'b0000};
        case (rm)
            3'd0:    inc = (r && (s || u[0])) ? 1 : 0;
            3'd1:    inc = 0;
            3'd2:    inc = ((r || s) && sign) ? 1 : 0;
            3'd3:    inc = ((r || s) && !sign) ? 1 : 0;
            default: inc = r ? 1 : 0;
        endcase
        mag = longint'(u[30:0]) + longint'(inc);
        ovf = mo || (ec == 2'b01) || (u[30:23] == 8'hFF) || ((mag >> 23) >= 255);
        if (ovf) begin
            to_inf = (rm == 3'd0) || (rm == 3'd4) || (rm == 3'd2 && sign) || (rm == 3'd3 && !sign);
            res = to_inf ? {sign, 8'hFF, 23'h0} : {sign, 8'hFE, 23'h7FFFFF};
        end else begin
            res = {sign, mag[30:0]};
        end
        nx = r || s || ovf;
        return {res, inv, 1'b0, ovf, nx && (u[30:23] == 8'h00), nx};
    endfunction

    // Reference pipe: enqueue every accepted input.
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i && valid_i && ready_o)
            q.push_back(model(urnd_i.u_result, urnd_i.rs, urnd_i.round_en, urnd_i.invalid,
                              urnd_i.exp_cout, rnd_i, mul_ovf_i));
    end

    // Compare process, sampled mid-cycle.
    always @(negedge clk_i) begin
        logic [36:0] e;
        if (!rst_ni) begin
            q.delete();
            chk("rst_valid_o", valid_o, 0);
            chk("rst_ready_o", ready_o, 1);
            chk("rst_result_o", result_o, 0);
            chk("rst_fflags_o", fflags_o, 0);
        end else if (flush_i) begin
            q.delete();
        end else begin
            chk("ready_o", ready_o, !(q.size() >= 2 && !ready_i));
            if (!ready_o) saw_stall = 1;
            if (q.size() == 0) chk("valid_idle", valid_o, 0);
            if (valid_o && ready_i && q.size() != 0) begin
                e = q.pop_front();
                chk("out_result", result_o, e[36:5]);
                chk("out_fflags", fflags_o, e[4:0]);
                n_out++;
            end
        end
    end

    // Offer one input and hold it until accepted (bounded). Called and returns at posedge+1.
    task automatic drive(input logic [31:0] u, input logic [1:0] rs, input logic re, input logic inv,
                         input logic [1:0] ec, input logic [2:0] rm, input logic mo);
        bit acc = 0;
        urnd_i    = {u, rs, re, inv, ec};
        rnd_i     = roundmode_e'(rm);
        mul_ovf_i = mo;
        valid_i   = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            acc = ready_o && !flush_i && rst_ni;
            @(posedge clk_i);
            #1;
            if (acc) break;
        end
        valid_i = 0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic directed(input string name, input logic [31:0] u, input logic [1:0] rs,
                            input logic re, input logic inv, input logic [1:0] ec, input logic [2:0] rm,
                            input logic mo, input logic [31:0] exp_res, input logic [4:0] exp_fl);
        ready_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        chk({name, "_model"}, model(u, rs, re, inv, ec, rm, mo), {exp_res, exp_fl});
        drive(u, rs, re, inv, ec, rm, mo);
        @(negedge clk_i);
        chk({name, "_lat1_valid"}, valid_o, 0);
        @(negedge clk_i);
        chk({name, "_lat2_valid"}, valid_o, 1);
        chk({name, "_res"}, result_o, exp_res);
        chk({name, "_flags"}, fflags_o, exp_fl);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk_i);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit done;
        rst_ni = 1; flush_i = 0; valid_i = 0; ready_i = 1; mul_ovf_i = 0;
        urnd_i = '0; rnd_i = RNE;
        #3 rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        @(posedge clk_i);
        #1;

        // name, u, rs, round_en, invalid, exp_cout, rm, mul_ovf, result, {NV,DZ,OF,UF,NX}
        directed("rne_tie",   32'h3F800001, 2'b10, 1, 0, 2'b00, 3'd0, 0, 32'h3F800002, 5'b00001);
        directed("carry_rne", 32'h3FFFFFFF, 2'b11, 1, 0, 2'b00, 3'd0, 0, 32'h40000000, 5'b00001);
        directed("carry_rtz", 32'h3FFFFFFF, 2'b11, 1, 0, 2'b00, 3'd1, 0, 32'h3FFFFFFF, 5'b00001);
        directed("ovf_rne",   32'h7F7FFFFF, 2'b10, 1, 0, 2'b00, 3'd0, 0, 32'h7F800000, 5'b00101);
        directed("ovf_rtz",   32'h7F7FFFFF, 2'b10, 1, 0, 2'b00, 3'd1, 0, 32'h7F7FFFFF, 5'b00001);
        directed("ovf_rdn",   32'hFF7FFFFF, 2'b10, 1, 0, 2'b00, 3'd2, 0, 32'hFF800000, 5'b00101);
        directed("sub_uf",    32'h00000010, 2'b01, 1, 0, 2'b00, 3'd0, 0, 32'h00000010, 5'b00011);
        directed("sub_carry", 32'h007FFFFF, 2'b11, 1, 0, 2'b00, 3'd0, 0, 32'h00800000, 5'b00011);
        directed("pass_rind", 32'hFFC00000, 2'b00, 0, 1, 2'b00, 3'd0, 0, 32'hFFC00000, 5'b10000);
        directed("rmm_up",    32'h3F800000, 2'b10, 1, 0, 2'b00, 3'd4, 0, 32'h3F800001, 5'b00001);
        directed("mulovf_rup_neg", 32'hC0000000, 2'b00, 1, 0, 2'b00, 3'd3, 1, 32'hFF7FFFFF, 5'b00101);
        directed("mulovf_rdn_pos", 32'h40000000, 2'b00, 1, 0, 2'b00, 3'd2, 1, 32'h7F7FFFFF, 5'b00101);
        directed("expcout_rne",    32'h40000000, 2'b00, 1, 0, 2'b01, 3'd0, 0, 32'h7F800000, 5'b00101);

        // Backpressure: 4 back-to-back inputs, ready_i low for cycles 2-4.
        saw_stall = 0;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    drive(32'h3F800000 + i, 2'b10, 1, 0, 2'b00, 3'd0, 0);
            end
            begin
                ready_i = 1;
                @(posedge clk_i); #1;
                @(posedge clk_i); #1;
                ready_i = 0;
                repeat (3) begin @(posedge clk_i); #1; end
                ready_i = 1;
            end
        join
        drain();
        chk("bp_stall_seen", saw_stall, 1);
        chk("bp_count", n_out - n0, 4);

        // Flush with both stages full.
        ready_i = 0;
        drive(32'h3F800001, 2'b11, 1, 0, 2'b00, 3'd0, 0);
        drive(32'h3F800002, 2'b11, 1, 0, 2'b00, 3'd0, 0);
        flush_i = 1;
        @(posedge clk_i); #1;
        flush_i = 0;
        @(negedge clk_i);
        chk("flush_valid_o", valid_o, 0);
        chk("flush_ready_o", ready_o, 1);
        @(posedge clk_i); #1;
        ready_i = 1;

        // Async reset pulse mid-burst.
        ready_i = 0;
        drive(32'h3F800003, 2'b01, 1, 0, 2'b00, 3'd3, 0);
        drive(32'h3F800004, 2'b01, 1, 0, 2'b00, 3'd3, 0);
        rst_ni = 0;
        #1;
        chk("rstpulse_valid_o", valid_o, 0);
        chk("rstpulse_result_o", result_o, 0);
        chk("rstpulse_fflags_o", fflags_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        ready_i = 1;
        @(posedge clk_i); #1;

        // Randomized traffic with random backpressure and occasional flush.
        done = 0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [7:0] e;
                    logic [22:0] m;
                    logic [1:0] ec;
                    case ($urandom_range(0, 5))
                        0: e = 8'h00;
                        1: e = 8'hFE;
                        2: e = 8'hFF;
                        3: e = 8'h01;
                        default: e = 8'($urandom);
                    endcase
                    case ($urandom_range(0, 3))
                        0: m = 23'h7FFFFF;
                        1: m = 23'h000000;
                        2: m = 23'h7FFFFE;
                        default: m = 23'($urandom);
                    endcase
                    ec = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
                    drive({1'($urandom), e, m}, 2'($urandom), $urandom_range(0, 7) != 0,
                          $urandom_range(0, 15) == 0, ec, 3'($urandom_range(0, 4)),
                          $urandom_range(0, 31) == 0);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk_i); #1;
                    ready_i = ($urandom_range(0, 9) < 7);
                    flush_i = ($urandom_range(0, 99) == 0);
                end
                ready_i = 1;
                flush_i = 0;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
